// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package bus_arb_pkg;

    localparam int unsigned ID_W      = 8;
    localparam int unsigned PKT_MAX_W = 64;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POP  = 2'd1;
    localparam logic [1:0] ST_PUSH = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        POP  = ST_POP,
        PUSH = ST_PUSH
    } state_t;

    // Destination ID lives in the top ID_W bits of a pkt_w-wide packet.
    function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                                input int unsigned         pkt_w);
        logic [PKT_MAX_W-1:0] sh;
        sh = pkt >> (pkt_w - ID_W);
        return sh[ID_W-1:0];
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority request picker: first requester after 'last', wrapping at drvrs.
module rr_picker #(
    parameter int unsigned drvrs = 5
) (
    input  logic [drvrs-1:0] req,
    input  logic [3:0]       last,
    output logic [3:0]       gnt_id,
    output logic             any
);

    logic [4:0] cand;
    logic       found;

    // Walk candidates last+1, last+2, ... (mod drvrs) and take the first requester.
    always_comb begin
        gnt_id = '0;
        found  = 1'b0;
        cand   = '0;
        any    = |req;
        for (int k = 1; k <= int'(drvrs); k++) begin
            cand = {1'b0, last} + 5'(k);
            if (cand >= 5'(drvrs)) begin
                cand = cand - 5'(drvrs);
            end
            for (int i = 0; i < int'(drvrs); i++) begin
                if (!found && req[i] && (cand == 5'(i))) begin
                    gnt_id = 4'(i);
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter/router for the shared device bus.
// Pops one packet from a pending device FIFO, then pushes it to its destination
// (or to every other device on broadcast). Optional statistics counters are
// enabled with the BUS_ARB_STATS_EN macro.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned pckg_sz   = 32,
    parameter int unsigned drvrs     = 5,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [drvrs-1:0][pckg_sz-1:0]   D_push,
    output logic [3:0]                      grant_id,
    output logic                            busy
`ifdef BUS_ARB_STATS_EN
   ,output logic [15:0]                     pkt_cnt,
    output logic [15:0]                     drop_cnt
`endif
);

    state_t               state_q;
    state_t               state_nxt;
    logic [3:0]           last_q;
    logic [pckg_sz-1:0]   pkt_reg;
    logic [3:0]           pick_id;
    logic                 pick_any;
    logic [pckg_sz-1:0]   head_pkt;
    logic                 head_pndng;
    logic [ID_W-1:0]      dest;
    logic [drvrs-1:0]     route_c;

    rr_picker #(.drvrs(drvrs)) u_picker (
        .req    (pndng),
        .last   (last_q),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    // Select the granted device's FIFO head and decode where its packet goes.
    always_comb begin
        head_pkt   = '0;
        head_pndng = 1'b0;
        for (int i = 0; i < int'(drvrs); i++) begin
            if (grant_id == 4'(i)) begin
                head_pkt   = D_pop[i];
                head_pndng = pndng[i];
            end
        end
        dest    = dest_of(PKT_MAX_W'(head_pkt), pckg_sz);
        route_c = '0;
        for (int i = 0; i < int'(drvrs); i++) begin
            if ((grant_id != 4'(i)) && ((dest == broadcast) || (dest == ID_W'(i)))) begin
                route_c[i] = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state; pop follows the granted FIFO's pending flag so a withdrawn packet is never popped.
    always_comb begin
        state_nxt = state_q;
        pop       = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = POP;
                end
            end
            POP: begin
                if (head_pndng) begin
                    state_nxt = PUSH;
                    for (int i = 0; i < int'(drvrs); i++) begin
                        pop[i] = (grant_id == 4'(i));
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            PUSH:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant capture, packet hold, registered push strobes and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_id <= '0;
            last_q   <= 4'(drvrs - 1);
            pkt_reg  <= '0;
            push     <= '0;
        end else begin
            push <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_id;
                    end
                end
                POP: begin
                    if (head_pndng) begin
                        pkt_reg <= head_pkt;
                        push    <= route_c;
                    end
                end
                PUSH: begin
                    last_q <= grant_id;
                end
                default: ;
            endcase
        end
    end

    assign D_push = {drvrs{pkt_reg}};
    assign busy   = (state_q != IDLE);

`ifdef BUS_ARB_STATS_EN
    // Saturating delivered / dropped packet counters, updated at the end of PUSH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else if (state_q == PUSH) begin
            if (|push) begin
                if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
            end else begin
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter (5 devices, 32-bit packets).
// Connects the statistics ports when BUS_ARB_STATS_EN is defined.
module tb_bus_rr_arbiter;

    localparam int N  = 5;
    localparam int W  = 32;
    localparam int NR = 400;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        pndng;
    logic [N-1:0][W-1:0] D_pop;
    logic [N-1:0]        pop;
    logic [N-1:0]        push;
    logic [N-1:0][W-1:0] D_push;
    logic [3:0]          grant_id;
    logic                busy;
`ifdef BUS_ARB_STATS_EN
    logic [15:0]         pkt_cnt;
    logic [15:0]         drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    bus_rr_arbiter #(.pckg_sz(W), .drvrs(N), .broadcast(8'hFF)) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .grant_id (grant_id),
        .busy     (busy)
`ifdef BUS_ARB_STATS_EN
       ,.pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic nc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        pndng = '0;
        D_pop = '0;
        nc();
        nc();
        reset = 1'b1;
    endtask

    // Expected routing of one packet from src, derived from the addressing rules.
    function automatic logic [N-1:0] route_of(input logic [W-1:0] pkt, input int src);
        logic [7:0]   d;
        logic [N-1:0] m;
        d = pkt[W-1 -: 8];
        m = '0;
        if (d == 8'hFF) begin
            for (int i = 0; i < N; i++) if (i != src) m[i] = 1'b1;
        end else if (int'(d) < N && int'(d) != src) begin
            m[int'(d)] = 1'b1;
        end
        return m;
    endfunction

    typedef struct {
        int           src;
        logic [W-1:0] pkt;
        logic [N-1:0] exp_pop;
        logic [N-1:0] exp_push;
    } vec_t;

    vec_t vecs [9];

    logic [W-1:0] q [N][$];
    logic [N-1:0] exp_pop  [NR+4];
    logic [N-1:0] exp_push [NR+4];
    logic         exp_busy [NR+4];
    logic         exp_dv   [NR+4];
    logic [W-1:0] exp_dp   [NR+4];
    logic         gid_set  [NR+4];
    logic [3:0]   gid_val  [NR+4];
    int           rm_idx   [NR+4];

    initial begin
        int seq3 [6];
        int seq6 [5];
        int m_deliv;
        int m_drop;
        int last_m;
        int free_at;
        logic [3:0] cur_gid;

        vecs[0] = '{0, 32'h09000000, 5'b00001, 5'b00000};
        vecs[1] = '{0, 32'h00000000, 5'b00001, 5'b00000};
        vecs[2] = '{2, 32'h04ABCDEF, 5'b00100, 5'b10000};
        vecs[3] = '{1, 32'hFF123456, 5'b00010, 5'b11101};
        vecs[4] = '{4, 32'h00C0FFEE, 5'b10000, 5'b00001};
        vecs[5] = '{3, 32'hFF000001, 5'b01000, 5'b10111};
        vecs[6] = '{4, 32'h04000000, 5'b10000, 5'b00000};
        vecs[7] = '{3, 32'h05000000, 5'b01000, 5'b00000};
        vecs[8] = '{0, 32'h01ABCDEF, 5'b00001, 5'b00010};
        seq3 = '{0, 1, 2, 3, 4, 0};
        seq6 = '{3, 4, 3, 4, 3};

        // Reset values.
        reset = 1'b0;
        pndng = '0;
        D_pop = '0;
        #1;
        chk("reset_pop", pop, 0);
        chk("reset_push", push, 0);
        chk("reset_dpush", D_push, 0);
        chk("reset_grant", grant_id, 0);
        chk("reset_busy", busy, 0);
        do_reset();

        // Single-packet vectors from an idle arbiter.
        m_deliv = 0;
        m_drop  = 0;
        for (int v = 0; v < 9; v++) begin
            for (int i = 0; i < N; i++) D_pop[i] = $urandom;
            D_pop[vecs[v].src] = vecs[v].pkt;
            pndng = '0;
            pndng[vecs[v].src] = 1'b1;
            nc();
            chk($sformatf("vec%0d_pop", v), pop, vecs[v].exp_pop);
            chk($sformatf("vec%0d_grant", v), grant_id, 4'(vecs[v].src));
            chk($sformatf("vec%0d_busy_pop", v), busy, 1);
            chk($sformatf("vec%0d_nopush_early", v), push, 0);
            nc();
            chk($sformatf("vec%0d_push", v), push, vecs[v].exp_push);
            chk($sformatf("vec%0d_dpush", v), D_push, {N{vecs[v].pkt}});
            chk($sformatf("vec%0d_pop_once", v), pop, 0);
            if (vecs[v].exp_push != 0) m_deliv++; else m_drop++;
            pndng = '0;
            nc();
            chk($sformatf("vec%0d_idle", v), busy, 0);
            chk($sformatf("vec%0d_push_1cyc", v), push, 0);
`ifdef BUS_ARB_STATS_EN
            if (v == 1) begin
                chk("stats_t5_drop", drop_cnt, 2);
                chk("stats_t5_pkt", pkt_cnt, 0);
            end
`endif
        end
`ifdef BUS_ARB_STATS_EN
        chk("stats_vec_pkt", pkt_cnt, 16'(m_deliv));
        chk("stats_vec_drop", drop_cnt, 16'(m_drop));
`endif

        // Pending flag withdrawn during POP: no pop, no push.
        D_pop[1] = 32'h00111111;
        pndng = 5'b00010;
        nc();
        chk("withdraw_pop_before", pop, 5'b00010);
        pndng = '0;
        #1;
        chk("withdraw_pop_gone", pop, 0);
        nc();
        chk("withdraw_push", push, 0);
        chk("withdraw_busy", busy, 0);

        // Reset during PUSH clears outputs at once; first grant afterwards is device 0.
        D_pop[2] = 32'h04ABCDEF;
        pndng = 5'b00100;
        nc();
        nc();
        chk("midrst_push_before", push, 5'b10000);
        reset = 1'b0;
        #1;
        chk("midrst_pop", pop, 0);
        chk("midrst_push", push, 0);
        chk("midrst_dpush", D_push, 0);
        chk("midrst_grant", grant_id, 0);
        chk("midrst_busy", busy, 0);
        pndng = 5'b11111;
        for (int i = 0; i < N; i++) D_pop[i] = 32'h09000000;
        nc();
        reset = 1'b1;
        nc();
        chk("midrst_first_grant", grant_id, 0);
        chk("midrst_first_pop", pop, 5'b00001);

        // All devices pending: grant order 0,1,2,3,4,0 at one grant per 3 cycles.
        do_reset();
        for (int i = 0; i < N; i++) D_pop[i] = 32'h09000000;
        pndng = 5'b11111;
        for (int g = 0; g < 6; g++) begin
            nc();
            chk($sformatf("rr_all_grant%0d", g), grant_id, 4'(seq3[g]));
            chk($sformatf("rr_all_pop%0d", g), pop, 5'(1) << seq3[g]);
            nc();
            nc();
        end

        // Devices 3 and 4 both pending: they alternate.
        do_reset();
        for (int i = 0; i < N; i++) D_pop[i] = 32'h01000000;
        pndng = 5'b11000;
        for (int g = 0; g < 5; g++) begin
            nc();
            chk($sformatf("rr34_grant%0d", g), grant_id, 4'(seq6[g]));
            nc();
            chk($sformatf("rr34_push%0d", g), push, 5'b00010);
            nc();
        end

        // Randomized traffic against a scheduled-event reference model.
        do_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        for (int t = 0; t < NR + 4; t++) begin
            exp_pop[t] = '0; exp_push[t] = '0; exp_busy[t] = 1'b0; exp_dv[t] = 1'b0;
            exp_dp[t] = '0; gid_set[t] = 1'b0; gid_val[t] = '0; rm_idx[t] = -1;
        end
        last_m = N - 1; free_at = 0; cur_gid = '0; m_deliv = 0; m_drop = 0;
        for (int t = 0; t < NR; t++) begin
            if (gid_set[t]) cur_gid = gid_val[t];
            chk("rand_pop", pop, exp_pop[t]);
            chk("rand_push", push, exp_push[t]);
            chk("rand_busy", busy, exp_busy[t]);
            chk("rand_grant", grant_id, cur_gid);
            if (exp_dv[t]) chk("rand_dpush", D_push, {N{exp_dp[t]}});
            if (rm_idx[t] >= 0) void'(q[rm_idx[t]].pop_front());
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0 && q[i].size() < 4) begin
                    logic [7:0]  d;
                    logic [23:0] pl;
                    int unsigned sel;
                    sel = $urandom_range(0, 7);
                    if (sel < 5)       d = 8'(sel);
                    else if (sel == 5) d = 8'hFF;
                    else if (sel == 6) d = 8'($urandom_range(5, 15));
                    else               d = 8'($urandom);
                    pl = 24'($urandom);
                    q[i].push_back({d, pl});
                end
            end
            if (t >= free_at) begin
                int g;
                g = -1;
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (last_m + k) % N;
                    if (g < 0 && q[c].size() > 0) g = c;
                end
                if (g >= 0) begin
                    logic [N-1:0] m;
                    m = route_of(q[g][0], g);
                    exp_pop[t+1]  = 5'(1) << g;
                    gid_set[t+1]  = 1'b1;
                    gid_val[t+1]  = 4'(g);
                    exp_busy[t+1] = 1'b1;
                    exp_busy[t+2] = 1'b1;
                    exp_push[t+2] = m;
                    exp_dv[t+2]   = 1'b1;
                    exp_dp[t+2]   = q[g][0];
                    rm_idx[t+2]   = g;
                    free_at       = t + 3;
                    last_m        = g;
                    if (m != 0) m_deliv++; else m_drop++;
                end
            end
            for (int i = 0; i < N; i++) begin
                pndng[i] = (q[i].size() > 0);
                D_pop[i] = (q[i].size() > 0) ? q[i][0] : W'($urandom);
            end
            nc();
        end
        pndng = '0;
        nc(); nc(); nc(); nc();
        chk("rand_drain_busy", busy, 0);
`ifdef BUS_ARB_STATS_EN
        chk("rand_stats_pkt", pkt_cnt, 16'(m_deliv));
        chk("rand_stats_drop", drop_cnt, 16'(m_drop));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
